// File: rtl/bridge_req_serializer.sv
// bridge_req_serializer
//
// Serializes one core-to-host command into 16-bit request words for the
// bridge driver, then waits for the host's response and reports completion.
// The optional timeout ends the wait if the host never answers.
//
// Word sequence for one request:
//   {count[2:0], code[12:0]}, then p0[31:16], p0[15:0], p1[31:16], ...
//
// Ports
//   clk             bridge clock
//   reset           asynchronous, active-high reset
//   cmd_valid       core request pending
//   cmd_ready       serializer can accept a request (IDLE only)
//   cmd_code        13-bit command code
//   cmd_param_count number of 32-bit params; 5..7 are treated as 4
//   cmd_params      params, param i at [32i+31:32i]
//   req_valid       req_word valid for the bridge driver
//   req_ready       bridge driver takes req_word this cycle
//   req_word        serialized request word
//   resp_valid      host response strobe
//   resp_status     host response status
//   done_valid      one-cycle completion pulse
//   done_status     captured status, 16'hFFFF on timeout
//   done_timeout    1 when the completion was a timeout
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | ready for a new request
// HEADER    | presenting the {count, code} header word
// PARAM_HI  | presenting bits 31:16 of param idx
// PARAM_LO  | presenting bits 15:0 of param idx
// WAIT_RESP | all words sent, waiting for resp_valid or timeout
// DONE      | done_valid pulse, then back to IDLE

module bridge_req_serializer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [12:0]  cmd_code,
  input  logic [2:0]   cmd_param_count,
  input  logic [127:0] cmd_params,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [15:0]  req_word,
  input  logic         resp_valid,
  input  logic [15:0]  resp_status,
  output logic         done_valid,
  output logic [15:0]  done_status,
  output logic         done_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PARAM_HI,
    PARAM_LO,
    WAIT_RESP,
    DONE
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t            state_q, state_d;
  logic [12:0]       code_q, code_d;
  logic [2:0]        count_q, count_d;
  logic [3:0][31:0]  params_q, params_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       tmr_q, tmr_d;
  logic [15:0]       dstat_q, dstat_d;
  logic              dto_q, dto_d;

  logic              last_param;
  logic              timeout_hit;
  logic              req_valid_c;
  logic [15:0]       req_word_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      code_q   <= '0;
      count_q  <= '0;
      params_q <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      dstat_q  <= '0;
      dto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      count_q  <= count_d;
      params_q <= params_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      dstat_q  <= dstat_d;
      dto_q    <= dto_d;
    end
  end

  // count_q is never 0 while in the param states, so count_q-1 cannot wrap there.
  assign last_param  = ({1'b0, idx_q} == (count_q - 3'd1));
  assign timeout_hit = TMO_EN && (tmr_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    count_d     = count_q;
    params_d    = params_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    dstat_d     = dstat_q;
    dto_d       = dto_q;
    req_valid_c = 1'b0;
    req_word_c  = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          code_d   = cmd_code;
          count_d  = (cmd_param_count > 3'd4) ? 3'd4 : cmd_param_count;
          params_d = cmd_params;
          idx_d    = '0;
          state_d  = HEADER;
        end
      end

      HEADER: begin
        req_valid_c = 1'b1;
        req_word_c  = {count_q, code_q};
        if (req_ready) begin
          idx_d = '0;
          if (count_q == 3'd0) begin
            tmr_d   = '0;
            state_d = WAIT_RESP;
          end else begin
            state_d = PARAM_HI;
          end
        end
      end

      PARAM_HI: begin
        req_valid_c = 1'b1;
        req_word_c  = params_q[idx_q][31:16];
        if (req_ready) state_d = PARAM_LO;
      end

      PARAM_LO: begin
        req_valid_c = 1'b1;
        req_word_c  = params_q[idx_q][15:0];
        if (req_ready) begin
          if (last_param) begin
            tmr_d   = '0;
            state_d = WAIT_RESP;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = PARAM_HI;
          end
        end
      end

      WAIT_RESP: begin
        // A response arriving on the last allowed cycle still counts as a response.
        if (resp_valid) begin
          dstat_d = resp_status;
          dto_d   = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          dstat_d = 16'hFFFF;
          dto_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset gates cmd_ready directly so it is low for the whole reset window.
  assign cmd_ready    = (state_q == IDLE) && !reset;
  assign req_valid    = req_valid_c;
  assign req_word     = req_word_c;
  assign done_valid   = (state_q == DONE);
  assign done_status  = dstat_q;
  assign done_timeout = dto_q;

endmodule

// File: tb/tb_bridge_req_serializer.sv
module tb_bridge_req_serializer;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [12:0]  cmd_code;
  logic [2:0]   cmd_param_count;
  logic [127:0] cmd_params;
  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_word;
  logic         resp_valid;
  logic [15:0]  resp_status;
  logic         done_valid;
  logic [15:0]  done_status;
  logic         done_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  bridge_req_serializer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_code        (cmd_code),
    .cmd_param_count (cmd_param_count),
    .cmd_params      (cmd_params),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_word        (req_word),
    .resp_valid      (resp_valid),
    .resp_status     (resp_status),
    .done_valid      (done_valid),
    .done_status     (done_status),
    .done_timeout    (done_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_params();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full request. resp_delay = wait cycle (0-based) on which the host
  // answers; anything >= TMO means no answer at all.
  task automatic run_req(input logic [12:0] code, input logic [2:0] pc,
                         input logic [127:0] prm, input int stall_pct,
                         input int stall_first, input int resp_delay,
                         input bit stray, input logic [15:0] rstat);
    logic [15:0] exp_q[$];
    int          eff;
    int          i;
    int          cyc;
    bit          answered;
    logic [15:0] exp_stat;
    logic        exp_to;

    eff = (pc > 3'd4) ? 4 : int'(pc);
    exp_q.delete();
    exp_q.push_back({3'(eff), code});
    for (int p = 0; p < eff; p++) begin
      exp_q.push_back(prm[p*32+16 +: 16]);
      exp_q.push_back(prm[p*32 +: 16]);
    end

    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_req_valid", 32'(req_valid), 32'd0);
    cmd_valid       = 1'b1;
    cmd_code        = code;
    cmd_param_count = pc;
    cmd_params      = prm;
    tick();
    // Inputs after acceptance must not matter.
    cmd_valid       = 1'b0;
    cmd_code        = 13'($urandom);
    cmd_param_count = 3'($urandom);
    cmd_params      = rand_params();

    i   = 0;
    cyc = 0;
    while (i < exp_q.size() && cyc < 400) begin
      req_ready  = (cyc < stall_first) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      resp_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      resp_status = 16'($urandom);
      chk("word_valid", 32'(req_valid), 32'd1);
      chk("word_value", 32'(req_word), 32'(exp_q[i]));
      chk("word_no_done", 32'(done_valid), 32'd0);
      tick();
      if (req_ready) i++;
      cyc++;
    end
    if (i < exp_q.size()) chk("word_bound", 32'(i), 32'(exp_q.size()));
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    answered = 1'b0;
    for (int w = 0; w < TMO; w++) begin
      chk("wait_req_valid", 32'(req_valid), 32'd0);
      chk("wait_no_done", 32'(done_valid), 32'd0);
      chk("wait_cmd_ready", 32'(cmd_ready), 32'd0);
      if (w == resp_delay) begin
        resp_valid  = 1'b1;
        resp_status = rstat;
      end
      tick();
      resp_valid = 1'b0;
      if (w == resp_delay) begin
        answered = 1'b1;
        break;
      end
    end

    exp_stat = answered ? rstat : 16'hFFFF;
    exp_to   = !answered;
    chk("done_valid", 32'(done_valid), 32'd1);
    chk("done_status", 32'(done_status), 32'(exp_stat));
    chk("done_timeout", 32'(done_timeout), 32'(exp_to));
    resp_valid  = 1'b1;  // stray strobe in IDLE must not disturb held status
    resp_status = 16'($urandom);
    tick();
    resp_valid = 1'b0;
    chk("done_pulse_one", 32'(done_valid), 32'd0);
    chk("back_idle", 32'(cmd_ready), 32'd1);
    chk("hold_status", 32'(done_status), 32'(exp_stat));
    chk("hold_timeout", 32'(done_timeout), 32'(exp_to));
  endtask

  initial begin
    logic [127:0] prm;

    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_code        = '0;
    cmd_param_count = '0;
    cmd_params      = '0;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_status     = '0;
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_word", 32'(req_word), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_status", 32'(done_status), 32'd0);
    chk("rst_done_timeout", 32'(done_timeout), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Reference request: 4180,1111,2222,3333,4444 then 6F6B
    prm = {64'd0, 32'h33334444, 32'h11112222};
    run_req(13'h0180, 3'd2, prm, 0, 0, 0, 1'b0, 16'h6F6B);

    // Count 0 with a 5-cycle stall; response at earliest point
    run_req(13'h0180, 3'd0, rand_params(), 0, 5, 0, 1'b0, 16'h1234);

    // Timeout
    run_req(13'h0ABC, 3'd1, rand_params(), 0, 0, 99, 1'b0, 16'h0000);

    // Response coincident with last timeout cycle, stray resp during words
    run_req(13'h1FFF, 3'd0, rand_params(), 0, 0, TMO - 1, 1'b1, 16'h5A5A);

    // Count 7 clamps to 4
    run_req(13'h0042, 3'd7, rand_params(), 30, 0, 3, 1'b0, 16'hBEEF);

    // Reset during PARAM_LO
    prm             = rand_params();
    cmd_valid       = 1'b1;
    cmd_code        = 13'h0155;
    cmd_param_count = 3'd2;
    cmd_params      = prm;
    tick();
    cmd_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_word", 32'(req_word), 32'(prm[15:0]));
    reset = 1'b1;
    #1;
    chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_req_word", 32'(req_word), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_done_status", 32'(done_status), 32'd0);
    req_ready = 1'b0;
    tick();
    chk("mid_rst_done_valid", 32'(done_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_no_done", 32'(done_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    run_req(13'h0777, 3'd3, rand_params(), 0, 0, 1, 1'b0, 16'hC0DE);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      run_req(13'($urandom), 3'($urandom_range(0, 7)), rand_params(),
              $urandom_range(0, 60), $urandom_range(0, 3),
              $urandom_range(0, 10), 1'($urandom_range(0, 1)),
              16'($urandom));
      for (int k = $urandom_range(0, 3); k > 0; k--) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
